// File: rtl/guess_pkg.sv
// Purpose: shared types, constants and BCD helpers for the guessing-game round controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package guess_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PLAY = 3'd2,
    WIN  = 3'd3,
    LOSE = 3'd4
  } state_t;

  localparam logic [7:0] BCD_ZERO  = 8'h00;
  localparam logic [7:0] BCD_MAX   = 8'h99;

  // Fibonacci LFSR: taps 8,6,5,4 map to bit indices 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
  localparam logic [7:0] LFSR_ALT  = 8'h5A;

  // Two-digit BCD decrement; callers never pass 00
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Two-digit BCD increment that sticks at 99
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    if (v == BCD_MAX)            return v;
    else if (v[3:0] == 4'd9)     return {v[7:4] + 4'd1, 4'd0};
    else                         return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/guess_round_ctrl_btn_edge.sv
// Purpose: two-flop synchronizer plus falling-edge detector for an active-low button.
// Latency: one-cycle press pulse registered 3 clk edges after the pin falls.
// Backpressure: none; a held button yields exactly one pulse.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  logic sync1, sync2, sync3;

  // Synchronize the pin, keep one stage of history, register the falling-edge pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      sync3 <= sync2;
      press <= sync3 & ~sync2;
    end
  end

endmodule

// File: rtl/guess_round_ctrl.sv
// Purpose: round sequencer (countdown, guess compare, hints, win/lose, counters); GUESS_LFSR_EN selects a random secret.
// Latency: button pin to result 4 clk, start pin to playing 5 clk, tick to time_bcd 1 clk.
// Backpressure: none; presses outside their valid states are dropped.
module guess_round_ctrl
  import guess_pkg::*;
#(
  parameter logic [7:0] TIME_INIT = 8'h60,
  parameter int          MAX_TRIES = 8,
  parameter logic [7:0] SECRET    = 8'hB5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_n,
  input  logic       submit_n,
  input  logic [7:0] guess,
  output logic [7:0] time_bcd,
  output logic       hint_hi,
  output logic       hint_lo,
  output logic       win,
  output logic       lose,
  output logic [3:0] tries,
  output logic [7:0] wins_bcd,
  output logic       playing
);

  localparam logic [3:0] TRIES_LIM = 4'(MAX_TRIES);

  state_t     state, state_nxt;
  logic [7:0] time_nxt, wins_nxt, secret, secret_nxt, load_val;
  logic [3:0] tries_nxt;
  logic       hint_hi_nxt, hint_lo_nxt, win_nxt, lose_nxt;
  logic       start_p, submit_p;

  btn_edge u_start  (.clk(clk), .rst(rst), .btn_n(start_n),  .press(start_p));
  btn_edge u_submit (.clk(clk), .rst(rst), .btn_n(submit_n), .press(submit_p));

`ifdef GUESS_LFSR_EN
  logic [7:0] lfsr;

  // Free-running LFSR; its value at LOAD becomes the secret
  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  end

  // Avoid handing out a secret that the switches already show
  assign load_val = (lfsr == guess) ? (lfsr ^ LFSR_ALT) : lfsr;
`else
  assign load_val = SECRET;
`endif

  // State and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      time_bcd <= TIME_INIT;
      tries    <= 4'd0;
      wins_bcd <= BCD_ZERO;
      hint_hi  <= 1'b0;
      hint_lo  <= 1'b0;
      win      <= 1'b0;
      lose     <= 1'b0;
      playing  <= 1'b0;
      secret   <= SECRET;
    end else begin
      state    <= state_nxt;
      time_bcd <= time_nxt;
      tries    <= tries_nxt;
      wins_bcd <= wins_nxt;
      hint_hi  <= hint_hi_nxt;
      hint_lo  <= hint_lo_nxt;
      win      <= win_nxt;
      lose     <= lose_nxt;
      playing  <= (state_nxt == PLAY);
      secret   <= secret_nxt;
    end
  end

  // Next-state and datapath: submit is resolved before the tick in the same cycle
  always_comb begin
    state_nxt   = state;
    time_nxt    = time_bcd;
    tries_nxt   = tries;
    wins_nxt    = wins_bcd;
    hint_hi_nxt = hint_hi;
    hint_lo_nxt = hint_lo;
    win_nxt     = win;
    lose_nxt    = lose;
    secret_nxt  = secret;
    case (state)
      IDLE, WIN, LOSE: begin
        if (start_p) state_nxt = LOAD;
      end
      LOAD: begin
        time_nxt    = TIME_INIT;
        tries_nxt   = 4'd0;
        hint_hi_nxt = 1'b0;
        hint_lo_nxt = 1'b0;
        win_nxt     = 1'b0;
        lose_nxt    = 1'b0;
        secret_nxt  = load_val;
        state_nxt   = PLAY;
      end
      PLAY: begin
        if (submit_p && guess == secret) begin
          tries_nxt   = tries + 4'd1;
          hint_hi_nxt = 1'b0;
          hint_lo_nxt = 1'b0;
          win_nxt     = 1'b1;
          wins_nxt    = bcd_inc_sat(wins_bcd);
          state_nxt   = WIN;
        end else begin
          if (submit_p) begin
            tries_nxt   = tries + 4'd1;
            hint_hi_nxt = (guess > secret);
            hint_lo_nxt = (guess < secret);
            if (tries_nxt == TRIES_LIM) begin
              lose_nxt  = 1'b1;
              state_nxt = LOSE;
            end
          end
          if (tick) begin
            time_nxt = bcd_dec(time_bcd);
            if (time_nxt == BCD_ZERO) begin
              lose_nxt  = 1'b1;
              state_nxt = LOSE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_guess_round_ctrl.sv
module tb_guess_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start_n = 1'b1;
  logic       submit_n = 1'b1;
  logic [7:0] guess = 8'h00;
  logic [7:0] time_bcd, wins_bcd;
  logic       hint_hi, hint_lo, win, lose, playing;
  logic [3:0] tries;

  int n_cmp = 0;
  int n_bad = 0;

  guess_round_ctrl #(.TIME_INIT(8'h60), .MAX_TRIES(8), .SECRET(8'hB5)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start_n(start_n), .submit_n(submit_n),
    .guess(guess), .time_bcd(time_bcd), .hint_hi(hint_hi), .hint_lo(hint_lo),
    .win(win), .lose(lose), .tries(tries), .wins_bcd(wins_bcd), .playing(playing)
  );

  always #10 clk = ~clk;

  // advance n edges, then settle 1 time unit past the edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic press_start();
    start_n = 1'b0;
    cyc(5);
    start_n = 1'b1;
    cyc(3);
  endtask

  task automatic press_submit(input logic [7:0] g);
    guess = g;
    submit_n = 1'b0;
    cyc(5);
    submit_n = 1'b1;
    cyc(3);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag, input logic [7:0] exp_wins);
    n_cmp++;
    if ({time_bcd, tries, wins_bcd, hint_hi, hint_lo, win, lose, playing} !==
        {8'h60, 4'd0, exp_wins, 5'b00000}) begin
      n_bad++;
      $display("FAIL %s: time=%h tries=%0d wins=%h hh=%b hl=%b win=%b lose=%b play=%b, want time=60 tries=0 wins=%h rest 0",
               tag, time_bcd, tries, wins_bcd, hint_hi, hint_lo, win, lose, playing, exp_wins);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    check_reset_vals("reset", 8'h00);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset_mid_round();
    press_start();
    for (int i = 0; i < 23; i++) do_tick();
    n_cmp++;
    if (time_bcd !== 8'h37 || playing !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_time: time=%h play=%b, want 37 1", time_bcd, playing);
    end
    rst = 1'b1;
    cyc(1);
    check_reset_vals("mid_reset", 8'h00);
    rst = 1'b0;
    cyc(2);
  endtask

  task automatic test_countdown();
    start_n = 1'b0;
    cyc(4);
    n_cmp++;
    if (playing !== 1'b0) begin
      n_bad++;
      $display("FAIL start_lat4: playing=%b, want 0", playing);
    end
    cyc(1);
    n_cmp++;
    if (playing !== 1'b1 || time_bcd !== 8'h60 || tries !== 4'd0) begin
      n_bad++;
      $display("FAIL start_lat5: play=%b time=%h tries=%0d, want 1 60 0", playing, time_bcd, tries);
    end
    start_n = 1'b1;
    cyc(3);
    for (int s = 59; s >= 0; s--) begin
      do_tick();
      n_cmp++;
      if (time_bcd !== to_bcd(s) || lose !== (s == 0)) begin
        n_bad++;
        $display("FAIL countdown: time=%h lose=%b, want %h %b", time_bcd, lose, to_bcd(s), (s == 0));
      end
    end
    n_cmp++;
    if (wins_bcd !== 8'h00 || playing !== 1'b0 || win !== 1'b0) begin
      n_bad++;
      $display("FAIL countdown_end: wins=%h play=%b win=%b, want 00 0 0", wins_bcd, playing, win);
    end
    do_tick();
    n_cmp++;
    if (time_bcd !== 8'h00) begin
      n_bad++;
      $display("FAIL frozen_lose: time=%h, want 00", time_bcd);
    end
  endtask

  task automatic test_guess_hints();
    press_start();
    n_cmp++;
    if (lose !== 1'b0 || time_bcd !== 8'h60) begin
      n_bad++;
      $display("FAIL load_clear: lose=%b time=%h, want 0 60", lose, time_bcd);
    end
    press_submit(8'hC0);
    n_cmp++;
    if ({hint_hi, hint_lo, tries} !== {2'b10, 4'd1}) begin
      n_bad++;
      $display("FAIL hint_hi: hh=%b hl=%b tries=%0d, want 1 0 1", hint_hi, hint_lo, tries);
    end
    press_submit(8'h10);
    n_cmp++;
    if ({hint_hi, hint_lo, tries} !== {2'b01, 4'd2}) begin
      n_bad++;
      $display("FAIL hint_lo: hh=%b hl=%b tries=%0d, want 0 1 2", hint_hi, hint_lo, tries);
    end
    press_submit(8'hB5);
    n_cmp++;
    if ({hint_hi, hint_lo, win, lose, tries, wins_bcd, playing} !== {4'b0010, 4'd3, 8'h01, 1'b0}) begin
      n_bad++;
      $display("FAIL win: hh=%b hl=%b win=%b lose=%b tries=%0d wins=%h play=%b, want 0 0 1 0 3 01 0",
               hint_hi, hint_lo, win, lose, tries, wins_bcd, playing);
    end
  endtask

  task automatic test_max_tries();
    press_start();
    n_cmp++;
    if (win !== 1'b0 || tries !== 4'd0) begin
      n_bad++;
      $display("FAIL load_clear_win: win=%b tries=%0d, want 0 0", win, tries);
    end
    for (int i = 1; i <= 8; i++) begin
      press_submit((i % 2) ? 8'hFF : 8'h00);
      n_cmp++;
      if (tries !== 4'(i) || lose !== (i == 8)) begin
        n_bad++;
        $display("FAIL max_tries: tries=%0d lose=%b, want %0d %b", tries, lose, i, (i == 8));
      end
    end
    press_submit(8'hB5);
    n_cmp++;
    if (tries !== 4'd8 || win !== 1'b0 || wins_bcd !== 8'h01) begin
      n_bad++;
      $display("FAIL ninth_submit: tries=%0d win=%b wins=%h, want 8 0 01", tries, win, wins_bcd);
    end
  endtask

  task automatic test_submit_with_tick();
    press_start();
    for (int i = 0; i < 59; i++) do_tick();
    n_cmp++;
    if (time_bcd !== 8'h01) begin
      n_bad++;
      $display("FAIL pre_01: time=%h, want 01", time_bcd);
    end
    guess = 8'hB5;
    submit_n = 1'b0;
    cyc(3);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    n_cmp++;
    if ({win, lose, time_bcd, wins_bcd} !== {2'b10, 8'h01, 8'h02}) begin
      n_bad++;
      $display("FAIL same_cycle: win=%b lose=%b time=%h wins=%h, want 1 0 01 02", win, lose, time_bcd, wins_bcd);
    end
    submit_n = 1'b1;
    cyc(3);
  endtask

  task automatic test_hold_and_start_in_play();
    press_start();
    do_tick();
    guess = 8'h00;
    submit_n = 1'b0;
    cyc(3);
    n_cmp++;
    if (tries !== 4'd0) begin
      n_bad++;
      $display("FAIL submit_lat3: tries=%0d, want 0", tries);
    end
    cyc(1);
    n_cmp++;
    if (tries !== 4'd1 || hint_lo !== 1'b1) begin
      n_bad++;
      $display("FAIL submit_lat4: tries=%0d hl=%b, want 1 1", tries, hint_lo);
    end
    cyc(996);
    submit_n = 1'b1;
    cyc(5);
    n_cmp++;
    if (tries !== 4'd1) begin
      n_bad++;
      $display("FAIL hold: tries=%0d, want 1", tries);
    end
    press_start();
    cyc(4);
    n_cmp++;
    if ({playing, tries, time_bcd, hint_hi, hint_lo} !== {1'b1, 4'd1, 8'h59, 2'b01}) begin
      n_bad++;
      $display("FAIL start_in_play: play=%b tries=%0d time=%h hh=%b hl=%b, want 1 1 59 0 1",
               playing, tries, time_bcd, hint_hi, hint_lo);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_round();
    test_countdown();
    test_guess_hints();
    test_max_tries();
    test_submit_with_tick();
    test_hold_and_start_in_play();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
